// File: rtl/general_register_pkg.sv
// Shared types and constants for the general-register write arbiter.
package general_register_pkg;

    localparam int unsigned REG_COUNT   = 8;
    localparam int unsigned REG_INDEX_W = 3;

    typedef enum logic [1:0] {
        WIDTH_BYTE  = 2'd0,
        WIDTH_WORD  = 2'd1,
        WIDTH_DWORD = 2'd2,
        WIDTH_RSVD  = 2'd3
    } width_e;

    typedef enum logic {
        REQ_EXEC = 1'b0,
        REQ_LOAD = 1'b1
    } req_e;

    localparam logic [3:0] MASK_LOW_BYTE  = 4'b0001;
    localparam logic [3:0] MASK_HIGH_BYTE = 4'b0010;
    localparam logic [3:0] MASK_WORD      = 4'b0011;
    localparam logic [3:0] MASK_DWORD     = 4'b1111;

    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_INDEX_W-1:0] idx);
        logic [REG_COUNT-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/general_register_lane_align.sv
// Maps an x86 register code and width onto a 32-bit register index, byte mask and lane-aligned data.
module general_register_lane_align
    import general_register_pkg::*;
(
    input  logic [REG_INDEX_W-1:0] index,
    input  width_e                 width,
    input  logic [31:0]            data,
    output logic [REG_INDEX_W-1:0] aligned_index,
    output logic [3:0]             byte_mask,
    output logic [31:0]            aligned_data
);

    always_comb begin
        aligned_index = index;
        byte_mask     = '0;
        aligned_data  = '0;
        unique case (width)
            WIDTH_BYTE: begin
                // Codes 4-7 are AH/CH/DH/BH: bits 15:8 of registers 0-3.
                if (index[2]) begin
                    aligned_index = {1'b0, index[1:0]};
                    byte_mask     = MASK_HIGH_BYTE;
                    aligned_data  = {16'h0000, data[7:0], 8'h00};
                end else begin
                    byte_mask     = MASK_LOW_BYTE;
                    aligned_data  = {24'h000000, data[7:0]};
                end
            end
            WIDTH_WORD: begin
                byte_mask    = MASK_WORD;
                aligned_data = {16'h0000, data[15:0]};
            end
            WIDTH_DWORD: begin
                byte_mask    = MASK_DWORD;
                aligned_data = data;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/general_register_write_arbiter.sv
// Arbitrates execute/load writebacks onto one register-file write port and tracks outstanding writes.
// GENERAL_REGISTER_ROUND_ROBIN_EN selects round-robin arbitration; otherwise the load requester always wins.
module general_register_write_arbiter
    import general_register_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [REG_INDEX_W-1:0] req0_index,
    input  logic [1:0]             req0_width,
    input  logic [31:0]            req0_data,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [REG_INDEX_W-1:0] req1_index,
    input  logic [1:0]             req1_width,
    input  logic [31:0]            req1_data,
    output logic                   wr_en,
    output logic [REG_INDEX_W-1:0] wr_index,
    output logic [3:0]             wr_byte_mask,
    output logic [31:0]            wr_data,
    input  logic                   reserve_valid,
    input  logic [REG_INDEX_W-1:0] reserve_index,
    output logic                   reserve_ready,
    output logic [REG_COUNT-1:0]   busy,
    output logic                   underflow_error
);

    logic eligible0;
    logic eligible1;
    logic grant0;
    logic grant1;
    logic grant_any;

    assign eligible0 = req0_valid && (width_e'(req0_width) != WIDTH_RSVD);
    assign eligible1 = req1_valid && (width_e'(req1_width) != WIDTH_RSVD);

`ifdef GENERAL_REGISTER_ROUND_ROBIN_EN
    req_e priority_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            priority_q <= REQ_EXEC;
        end else if (grant0) begin
            priority_q <= REQ_LOAD;
        end else if (grant1) begin
            priority_q <= REQ_EXEC;
        end
    end

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (priority_q == REQ_EXEC) begin
            grant0 = eligible0;
            grant1 = eligible1 && !eligible0;
        end else begin
            grant1 = eligible1;
            grant0 = eligible0 && !eligible1;
        end
    end
`else
    assign grant1 = eligible1;
    assign grant0 = eligible0 && !eligible1;
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign grant_any  = grant0 || grant1;

    logic [REG_INDEX_W-1:0] aligned_index;
    logic [3:0]             aligned_mask;
    logic [31:0]            aligned_data;

    general_register_lane_align u_lane_align (
        .index         (grant1 ? req1_index : req0_index),
        .width         (width_e'(grant1 ? req1_width : req0_width)),
        .data          (grant1 ? req1_data : req0_data),
        .aligned_index (aligned_index),
        .byte_mask     (aligned_mask),
        .aligned_data  (aligned_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_en        <= 1'b0;
            wr_index     <= '0;
            wr_byte_mask <= '0;
            wr_data      <= '0;
        end else begin
            wr_en <= grant_any;
            if (grant_any) begin
                wr_index     <= aligned_index;
                wr_byte_mask <= aligned_mask;
                wr_data      <= aligned_data;
            end
        end
    end

    logic [1:0]           count_q    [REG_COUNT];
    logic [1:0]           count_next [REG_COUNT];
    logic [REG_COUNT-1:0] inc_vec;
    logic [REG_COUNT-1:0] dec_vec;
    logic [REG_COUNT-1:0] busy_next;
    logic                 reserve_fire;
    logic                 underflow_set;

    assign reserve_ready = (count_q[reserve_index] != 2'd3);
    assign reserve_fire  = reserve_valid && reserve_ready;
    assign inc_vec       = reserve_fire ? reg_onehot(reserve_index) : '0;
    assign dec_vec       = wr_en ? reg_onehot(wr_index) : '0;

    // A reserve and a completion on the same register cancel, including at count 0.
    always_comb begin
        underflow_set = 1'b0;
        busy_next     = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            count_next[i] = count_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                count_next[i] = count_q[i] + 2'd1;
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (count_q[i] == 2'd0) begin
                    underflow_set = 1'b1;
                end else begin
                    count_next[i] = count_q[i] - 2'd1;
                end
            end
            busy_next[i] = (count_next[i] != 2'd0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                count_q[i] <= '0;
            end
            busy            <= '0;
            underflow_error <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                count_q[i] <= count_next[i];
            end
            busy            <= busy_next;
            underflow_error <= underflow_error || underflow_set;
        end
    end

endmodule
